// File: rtl/crc_frame_ctrl_pkg.sv
// crc_frame_ctrl_pkg
// Shared types and project defaults for the serial CRC frame controller.
//   state_e     : controller FSM states (idle, data shift, CRC output).
//   CrcWidthDef : default CRC/LFSR width for the project polynomial.
//   TapsDef     : default feedback tap mask (bit CRC_WIDTH-1 unused).
//   SeedDef     : default LFSR seed loaded on every frame accept.
//   cnt_width() : counter width able to count the longer of the two phases.
package crc_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StOut   = 2'd2
  } state_e;

  localparam int unsigned CrcWidthDef = 8;
  localparam logic [7:0]  TapsDef     = 8'h08;
  localparam logic [7:0]  SeedDef     = 8'h00;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// crc_lfsr
// Serial CRC register. One operation per clock, in priority order:
//   load  : state <= SEED
//   step  : fold one data bit in (fb = din ^ state[0], shift right, XOR taps)
//   drain : shift right with zero fill (serialises the CRC LSB first)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state cleared to 0)
//   i_load     : load the seed
//   i_step     : absorb i_din
//   i_din      : serial data bit
//   i_drain    : shift right, zero fill
//   o_lsb      : current state bit 0 (serial CRC bit)
//   o_next     : full next-state value (what the register holds after this edge)
module crc_lfsr
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned          CRC_WIDTH = CrcWidthDef,
  parameter logic [CRC_WIDTH-1:0] TAPS      = CRC_WIDTH'(TapsDef),
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(SeedDef)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_din,
  input  logic                 i_drain,
  output logic                 o_lsb,
  output logic [CRC_WIDTH-1:0] o_next
);

  logic [CRC_WIDTH-1:0] r_lfsr;
  logic [CRC_WIDTH-1:0] w_next;
  logic                 w_fb;

  assign w_fb = i_din ^ r_lfsr[0];

  always_comb begin
    w_next = r_lfsr;
    if (i_load) begin
      w_next = SEED;
    end else if (i_step) begin
      // TAPS[CRC_WIDTH-1] is never consulted: the top bit always takes fb.
      for (int unsigned i = 0; i < CRC_WIDTH - 1; i++) begin
        w_next[i] = r_lfsr[i+1] ^ (w_fb & TAPS[i]);
      end
      w_next[CRC_WIDTH-1] = w_fb;
    end else if (i_drain) begin
      w_next = r_lfsr >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign o_lsb  = r_lfsr[0];
  assign o_next = w_next;

endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl
// Handshaked serial CRC frame controller. Accepts one DATA_WIDTH word in IDLE,
// shifts it LSB first through the CRC LFSR (DATA_WIDTH cycles), streams the
// CRC out LSB first (CRC_WIDTH cycles) and pulses done_tick on return to IDLE.
// Frame period is DATA_WIDTH + CRC_WIDTH + 1 cycles; back-to-back accepts work.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (aborts any frame)
//   data_in     : frame word, sampled on accept
//   data_valid  : producer has a word
//   data_ready  : high only in IDLE
//   crc_out     : serial CRC bit, qualified by crc_valid
//   crc_valid   : high during the CRC output phase
//   crc_par     : final CRC, captured at end of shift, held until the next one
//   busy        : frame in progress
//   done_tick   : one-cycle pulse after the last CRC bit
module crc_frame_ctrl
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          CRC_WIDTH  = CrcWidthDef,
  parameter logic [CRC_WIDTH-1:0] TAPS       = CRC_WIDTH'(TapsDef),
  parameter logic [CRC_WIDTH-1:0] SEED       = CRC_WIDTH'(SeedDef)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  crc_out,
  output logic                  crc_valid,
  output logic [CRC_WIDTH-1:0]  crc_par,
  output logic                  busy,
  output logic                  done_tick
);

  localparam int unsigned    CntW        = cnt_width(DATA_WIDTH, CRC_WIDTH);
  localparam logic [CntW-1:0] CntDataLast = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] CntCrcLast  = CntW'(CRC_WIDTH - 1);

  state_e                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_sreg, w_sreg_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [CRC_WIDTH-1:0]  r_crc_par;
  logic                  r_done, w_done_d;

  logic                  w_load;
  logic                  w_step;
  logic                  w_drain;
  logic                  w_par_en;
  logic                  w_lfsr_lsb;
  logic [CRC_WIDTH-1:0]  w_lfsr_next;

  crc_lfsr #(
    .CRC_WIDTH (CRC_WIDTH),
    .TAPS      (TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_din   (r_sreg[0]),
    .i_drain (w_drain),
    .o_lsb   (w_lfsr_lsb),
    .o_next  (w_lfsr_next)
  );

  always_comb begin
    w_state_d = r_state;
    w_sreg_d  = r_sreg;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_drain   = 1'b0;
    w_par_en  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // data_ready is simply "in IDLE", so data_valid alone means accept.
        if (data_valid) begin
          w_sreg_d  = data_in;
          w_load    = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_step   = 1'b1;
        w_sreg_d = r_sreg >> 1;
        if (r_cnt == CntDataLast) begin
          // Capture the post-step value so crc_par is valid in the first OUT cycle.
          w_par_en  = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StOut;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StOut: begin
        w_drain = 1'b1;
        if (r_cnt == CntCrcLast) begin
          w_cnt_d   = '0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_crc_par <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sreg  <= w_sreg_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
      if (w_par_en) begin
        r_crc_par <= w_lfsr_next;
      end
    end
  end

  // All outputs decode from registers only.
  assign data_ready = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign crc_valid  = (r_state == StOut);
  assign crc_out    = (r_state == StOut) & w_lfsr_lsb;
  assign crc_par    = r_crc_par;
  assign done_tick  = r_done;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl
// Directed and randomised checks of crc_frame_ctrl at default parameters
// (DATA_WIDTH = CRC_WIDTH = 8, TAPS = 8'h08, SEED = 8'h00).
module tb_crc_frame_ctrl;

  localparam logic [7:0] TapsTb = 8'h08;
  localparam logic [7:0] SeedTb = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       crc_out;
  logic       crc_valid;
  logic [7:0] crc_par;
  logic       busy;
  logic       done_tick;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_par = 8'h00;

  always #5 clk = ~clk;

  crc_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid),
    .crc_par    (crc_par),
    .busy       (busy),
    .done_tick  (done_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference of the update rule, written as whole-word shifts.
  function automatic logic [7:0] crc_model(input logic [7:0] d);
    logic [7:0] l;
    logic       fb;
    l = SeedTb;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ l[0];
      l  = {fb, l[7:1]} ^ ({8{fb}} & TapsTb & 8'h7F);
    end
    return l;
  endfunction

  // Call at a falling edge; accept happens at the next rising edge (edge 0).
  // mode 0: drop valid after accept; 1: keep valid high presenting alt;
  // 2: toggle valid presenting alt while busy.
  task automatic run_frame(input logic [7:0] word, input logic [7:0] exp_par,
                           input int mode, input logic [7:0] alt, input string name);
    logic exp_bit;
    data_in    = word;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (mode == 0) begin
      data_valid = 1'b0;
    end else begin
      data_in = alt;
      if (mode == 2) data_valid = 1'b0;
    end
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_bit = 1'b0;
      if (c >= 9 && c <= 16) exp_bit = exp_par[c-9];
      check_eq($sformatf("%s c%0d data_ready", name, c), data_ready, (c == 17));
      check_eq($sformatf("%s c%0d busy", name, c), busy, (c <= 16));
      check_eq($sformatf("%s c%0d crc_valid", name, c), crc_valid, (c >= 9 && c <= 16));
      check_eq($sformatf("%s c%0d crc_out", name, c), crc_out, exp_bit);
      check_eq($sformatf("%s c%0d done_tick", name, c), done_tick, (c == 17));
      if (c == 8) check_eq($sformatf("%s crc_par held", name), crc_par, last_par);
      if (c == 9 || c == 17) check_eq($sformatf("%s c%0d crc_par", name, c), crc_par, exp_par);
      if (mode == 2 && c < 17) data_valid = ~data_valid;
    end
    if (mode != 1) data_valid = 1'b0;
    last_par = exp_par;
  endtask

  initial begin
    logic       seen;
    logic [7:0] w;
    int         gap;

    #1 rst_n = 1'b0;
    #2;
    check_eq("rst data_ready", data_ready, 1'b1);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst crc_valid", crc_valid, 1'b0);
    check_eq("rst crc_out", crc_out, 1'b0);
    check_eq("rst done_tick", done_tick, 1'b0);
    check_eq("rst crc_par", crc_par, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed vectors.
    run_frame(8'h01, 8'h10, 0, 8'h00, "w01");
    run_frame(8'h00, 8'h00, 0, 8'h00, "w00");
    run_frame(8'h80, 8'h88, 0, 8'h00, "w80");
    run_frame(8'hFF, 8'h0F, 0, 8'h00, "wFF");

    // Producer holds valid high: second accept lands in cycle 17.
    run_frame(8'h01, 8'h10, 1, 8'h00, "b2b_a");
    run_frame(8'h00, 8'h00, 0, 8'h00, "b2b_b");

    // Valid toggling with a different word while busy must be ignored.
    run_frame(8'h01, 8'h10, 2, 8'hFF, "toggle");

    // Reset in the fifth SHIFT cycle.
    data_in    = 8'h01;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid rst data_ready", data_ready, 1'b1);
    check_eq("mid rst busy", busy, 1'b0);
    check_eq("mid rst crc_valid", crc_valid, 1'b0);
    check_eq("mid rst crc_out", crc_out, 1'b0);
    check_eq("mid rst done_tick", done_tick, 1'b0);
    check_eq("mid rst crc_par", crc_par, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_tick || busy || crc_valid) seen = 1'b1;
    end
    check_eq("no activity after reset", seen, 1'b0);
    last_par = 8'h00;
    run_frame(8'h01, 8'h10, 0, 8'h00, "post_rst");

    // Random words with random idle gaps against the model.
    for (int n = 0; n < 1000; n++) begin
      w   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      run_frame(w, crc_model(w), 0, 8'h00, $sformatf("rnd%0d_%02h", n, w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
